// File: rtl/reg_step_sequencer_pkg.sv
// Shared constants for reg_step_sequencer: downstream register control codes,
// command op encodings and FSM state encodings.
`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 3
`endif

package reg_step_sequencer_pkg;

  localparam int REG_CTRL_W = `REG_CTRL_WIDTH;

  // NOP is the idle code; it must stay distinct from every active code.
  localparam logic [REG_CTRL_W-1:0] REG_CTRL_NOP = REG_CTRL_W'(0);
  localparam logic [REG_CTRL_W-1:0] REG_CTRL_LD  = REG_CTRL_W'(1);
  localparam logic [REG_CTRL_W-1:0] REG_CTRL_INC = REG_CTRL_W'(2);
  localparam logic [REG_CTRL_W-1:0] REG_CTRL_DEC = REG_CTRL_W'(3);
  localparam logic [REG_CTRL_W-1:0] REG_CTRL_CLR = REG_CTRL_W'(4);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_ADD   = 2'b01,
    OP_SUB   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reg_step_sequencer_step_counter.sv
// Remaining-step down-counter: load, decrement, zero flag.
module step_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 sync_reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/reg_step_sequencer.sv
// Sequences LOAD/ADD/SUB/CLEAR commands into per-cycle register control codes
// and keeps a shadow copy. Optional saturation: define REG_STEP_SAT_EN.
`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 3
`endif

module reg_step_sequencer
  import reg_step_sequencer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  // cmd handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE.
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [WIDTH-1:0]           cmd_data,
  input  logic [CNT_WIDTH-1:0]       cmd_count,
  output logic [`REG_CTRL_WIDTH-1:0] reg_ctrl,
  output logic [WIDTH-1:0]           reg_data,
  output logic [WIDTH-1:0]           shadow,
  output logic                       done,
  output logic                       sat,
  output state_e                     state_dbg
);

  state_e                  state_d, state_q;
  logic [REG_CTRL_W-1:0]   reg_ctrl_d, reg_ctrl_q;
  logic [WIDTH-1:0]        reg_data_d, reg_data_q;
  logic [WIDTH-1:0]        shadow_d, shadow_q;
  logic                    done_d, done_q;
  logic                    sat_d, sat_q;
  logic                    cnt_load, cnt_dec, cnt_zero;
  logic [CNT_WIDTH-1:0]    cnt_load_val;
  logic                    add_sat, sub_sat;

  step_counter #(.CNT_WIDTH(CNT_WIDTH)) u_step_counter (
    .clk        (clk),
    .sync_reset (sync_reset),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // Shadow follows the code currently on reg_ctrl, exactly as the downstream register does.
  always_comb begin
    shadow_d = shadow_q;
    case (reg_ctrl_q)
      REG_CTRL_LD:  shadow_d = reg_data_q;
      REG_CTRL_INC: shadow_d = shadow_q + WIDTH'(1);
      REG_CTRL_DEC: shadow_d = shadow_q - WIDTH'(1);
      REG_CTRL_CLR: shadow_d = '0;
      default:      shadow_d = shadow_q;
    endcase
  end

`ifdef REG_STEP_SAT_EN
  // Decide on the value the register will hold once the current code lands.
  assign add_sat = (shadow_d == '1);
  assign sub_sat = (shadow_d == '0);
`else
  assign add_sat = 1'b0;
  assign sub_sat = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    reg_ctrl_d   = REG_CTRL_NOP;
    reg_data_d   = '0;
    done_d       = 1'b0;
    sat_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_LOAD: begin
              reg_ctrl_d = REG_CTRL_LD;
              reg_data_d = cmd_data;
              cnt_load   = 1'b1;
              state_d    = ST_STEP;
            end
            OP_CLEAR: begin
              reg_ctrl_d = REG_CTRL_CLR;
              cnt_load   = 1'b1;
              state_d    = ST_STEP;
            end
            default: begin
              if (cmd_count == '0) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end else if ((cmd_op == OP_ADD) ? add_sat : sub_sat) begin
                done_d  = 1'b1;
                sat_d   = 1'b1;
                state_d = ST_DONE;
              end else begin
                reg_ctrl_d   = (cmd_op == OP_ADD) ? REG_CTRL_INC : REG_CTRL_DEC;
                cnt_load     = 1'b1;
                cnt_load_val = cmd_count - CNT_WIDTH'(1);
                state_d      = ST_STEP;
              end
            end
          endcase
        end
      end
      ST_STEP: begin
        if (cnt_zero) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (((reg_ctrl_q == REG_CTRL_INC) && add_sat) ||
                     ((reg_ctrl_q == REG_CTRL_DEC) && sub_sat)) begin
          done_d  = 1'b1;
          sat_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          reg_ctrl_d = reg_ctrl_q;
          cnt_dec    = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q    <= ST_IDLE;
      reg_ctrl_q <= REG_CTRL_NOP;
      reg_data_q <= '0;
      shadow_q   <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_ctrl_q <= reg_ctrl_d;
      reg_data_q <= reg_data_d;
      shadow_q   <= shadow_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign reg_ctrl  = reg_ctrl_q;
  assign reg_data  = reg_data_q;
  assign shadow    = shadow_q;
  assign done      = done_q;
  assign sat       = sat_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_step_sequencer.sv
// Directed bench for reg_step_sequencer paired with a downstream register model.
module tb_reg_step_sequencer;
  import reg_step_sequencer_pkg::*;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  sync_reset = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [1:0]            cmd_op = 2'b00;
  logic [WIDTH-1:0]      cmd_data = '0;
  logic [CNT_WIDTH-1:0]  cmd_count = '0;
  logic [REG_CTRL_W-1:0] reg_ctrl;
  logic [WIDTH-1:0]      reg_data;
  logic [WIDTH-1:0]      shadow;
  logic                  done;
  logic                  sat;
  state_e                state_dbg;

  logic [WIDTH-1:0]      dn_q;
  int                    total = 0;
  int                    bad = 0;
  bit                    mon_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  reg_step_sequencer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .reg_ctrl   (reg_ctrl),
    .reg_data   (reg_data),
    .shadow     (shadow),
    .done       (done),
    .sat        (sat),
    .state_dbg  (state_dbg)
  );

  // downstream register driven by the sequencer
  always @(posedge clk) begin
    if (sync_reset) dn_q <= '0;
    else begin
      case (reg_ctrl)
        REG_CTRL_LD:  dn_q <= reg_data;
        REG_CTRL_INC: dn_q <= dn_q + 8'd1;
        REG_CTRL_DEC: dn_q <= dn_q - 8'd1;
        REG_CTRL_CLR: dn_q <= 8'd0;
        default:      dn_q <= dn_q;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) check("shadow_vs_dn", 32'(shadow), 32'(dn_q));
  end

  // driver: offer a command for one edge; returns at the negedge after acceptance
  task automatic send(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt,
                      input bit keep);
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = cnt;
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  // expects n issued cycles of code, then done, then an IDLE cycle
  task automatic expect_run(input logic [REG_CTRL_W-1:0] code, input logic [7:0] data,
                            input int n, input logic [7:0] exp_sh, input bit exp_sat);
    for (int i = 1; i <= n + 1; i++) begin
      if (i > 1) @(negedge clk);
      if (i <= n) begin
        check("issue_code", 32'(reg_ctrl), 32'(code));
        if (code == REG_CTRL_LD) check("issue_data", 32'(reg_data), 32'(data));
        check("no_early_done", 32'(done), 32'd0);
        check("busy", 32'(cmd_ready), 32'd0);
      end else begin
        check("done", 32'(done), 32'd1);
        check("done_nop", 32'(reg_ctrl), 32'(REG_CTRL_NOP));
        check("done_data0", 32'(reg_data), 32'd0);
        check("done_shadow", 32'(shadow), 32'(exp_sh));
        check("done_sat", 32'(sat), 32'(exp_sat));
        check("done_busy", 32'(cmd_ready), 32'd0);
      end
    end
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_done0", 32'(done), 32'd0);
    check("idle_nop", 32'(reg_ctrl), 32'(REG_CTRL_NOP));
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'(reg_ctrl), 32'(REG_CTRL_NOP));
    check("rst_data", 32'(reg_data), 32'd0);
    check("rst_shadow", 32'(shadow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    sync_reset = 1'b0;
    mon_en = 1'b1;

    send(OP_LOAD, 8'h5A, 4'd0, 1'b0);
    expect_run(REG_CTRL_LD, 8'h5A, 1, 8'h5A, 1'b0);

    send(OP_ADD, 8'h00, 4'd3, 1'b0);
    expect_run(REG_CTRL_INC, 8'h00, 3, 8'h5D, 1'b0);

    send(OP_CLEAR, 8'hFF, 4'd7, 1'b0);
    expect_run(REG_CTRL_CLR, 8'h00, 1, 8'h00, 1'b0);

    send(OP_SUB, 8'h00, 4'd0, 1'b0);
    expect_run(REG_CTRL_DEC, 8'h00, 0, 8'h00, 1'b0);

    send(OP_SUB, 8'h00, 4'd2, 1'b0);
`ifdef REG_STEP_SAT_EN
    expect_run(REG_CTRL_DEC, 8'h00, 0, 8'h00, 1'b1);
`else
    expect_run(REG_CTRL_DEC, 8'h00, 2, 8'hFE, 1'b0);
`endif

    send(OP_LOAD, 8'hFE, 4'd0, 1'b0);
    expect_run(REG_CTRL_LD, 8'hFE, 1, 8'hFE, 1'b0);

    send(OP_ADD, 8'h00, 4'd4, 1'b0);
`ifdef REG_STEP_SAT_EN
    expect_run(REG_CTRL_INC, 8'h00, 1, 8'hFF, 1'b1);
`else
    expect_run(REG_CTRL_INC, 8'h00, 4, 8'h02, 1'b0);
`endif

    // reset on the second INC of ADD 8
    send(OP_LOAD, 8'h10, 4'd0, 1'b0);
    expect_run(REG_CTRL_LD, 8'h10, 1, 8'h10, 1'b0);
    send(OP_ADD, 8'h00, 4'd8, 1'b0);
    check("pre_rst_inc1", 32'(reg_ctrl), 32'(REG_CTRL_INC));
    @(negedge clk);
    check("pre_rst_inc2", 32'(reg_ctrl), 32'(REG_CTRL_INC));
    sync_reset = 1'b1;
    @(negedge clk);
    sync_reset = 1'b0;
    check("midrst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("midrst_ctrl", 32'(reg_ctrl), 32'(REG_CTRL_NOP));
    check("midrst_data", 32'(reg_data), 32'd0);
    check("midrst_shadow", 32'(shadow), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_done", 32'(done), 32'd0);
      check("postrst_nop", 32'(reg_ctrl), 32'(REG_CTRL_NOP));
    end

    // cmd_valid held through STEP/DONE with a different op: ignored until IDLE
    send(OP_ADD, 8'h00, 4'd2, 1'b1);
    cmd_op   = OP_LOAD;
    cmd_data = 8'h33;
    expect_run(REG_CTRL_INC, 8'h00, 2, 8'h02, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    expect_run(REG_CTRL_LD, 8'h33, 1, 8'h33, 1'b0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
